// File: rtl/rom_readback_if.sv
// ROM port A and pipe-out FIFO write side seen by the readback engine.
// Handshake: a word transfers on a core_clk edge where fifo_wr=1; fifo_wr is only raised while fifo_full=0.
interface rom_readback_if;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] fifo_din;
  logic        fifo_wr;
  logic        fifo_full;

  modport master (
    output mem_en,
    output mem_addr,
    input  mem_dout,
    output fifo_din,
    output fifo_wr,
    input  fifo_full
  );

  modport slave (
    input  mem_en,
    input  mem_addr,
    output mem_dout,
    input  fifo_din,
    input  fifo_wr,
    output fifo_full
  );
endinterface

// File: rtl/rom_readback.sv
// Reads a host-sized image back out of program ROM, one word per ISSUE/WAIT/PUSH pass,
// into the pipe-out FIFO, keeping a word count and a running 32-bit checksum.
module rom_readback #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 16384
) (
  input  logic                 core_clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          byte_count,
  rom_readback_if.master       bus,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          words_sent,
  output logic [31:0]          checksum,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_PUSH  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [32:0] MAX_W33 = 33'(MAX_WORDS);

  state_t      state_q, state_d;
  logic        start_q;
  logic [31:0] total_q;
  logic [31:0] index_q;
  logic [31:0] hold_q;
  logic [31:0] addr_q;

  logic [32:0] words_raw;
  logic [31:0] total_clamped;
  logic        start_accept;
  logic        push_fire;
  logic        last_word;

  // Round up to whole words in 33 bits so byte_count near 2^32 cannot wrap.
  assign words_raw     = ({1'b0, byte_count} + 33'd3) >> 2;
  assign total_clamped = (words_raw > MAX_W33) ? MAX_W33[31:0] : words_raw[31:0];
  assign start_accept  = start && !start_q && (state_q == S_IDLE);
  assign push_fire     = (state_q == S_PUSH) && !bus.fifo_full;
  assign last_word     = ((index_q + 32'd1) == total_q);

  assign bus.mem_en   = (state_q == S_ISSUE);
  assign bus.mem_addr = addr_q;
  assign bus.fifo_din = hold_q;
  assign bus.fifo_wr  = push_fire;
  assign state_dbg    = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_accept) state_d = (total_clamped == 32'd0) ? S_DONE : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = S_PUSH;
      S_PUSH:  if (push_fire) state_d = last_word ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      total_q    <= 32'd0;
      index_q    <= 32'd0;
      hold_q     <= 32'd0;
      addr_q     <= BASE_ADDR;
      busy       <= 1'b0;
      done       <= 1'b0;
      words_sent <= 32'd0;
      checksum   <= 32'd0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      if (start_accept) begin
        total_q    <= total_clamped;
        index_q    <= 32'd0;
        addr_q     <= BASE_ADDR;
        done       <= 1'b0;
        words_sent <= 32'd0;
        checksum   <= 32'd0;
        busy       <= 1'b1;
      end
      if (state_q == S_WAIT) hold_q <= bus.mem_dout;
      // Address for the next word is staged here so it holds steady through any stall.
      if (push_fire) begin
        words_sent <= words_sent + 32'd1;
        checksum   <= checksum + hold_q;
        index_q    <= index_q + 32'd1;
        addr_q     <= BASE_ADDR + ((index_q + 32'd1) << 2);
      end
      if (state_q == S_DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_readback.sv
// Bench for rom_readback: ROM and FIFO back-pressure modelled here, cycle-level
// expectations derived from word count, 3-cycle cadence and stall cycles.
module tb_rom_readback;
  logic        core_clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] byte_count;
  logic        busy;
  logic        done;
  logic [31:0] words_sent;
  logic [31:0] checksum;
  logic [2:0]  state_dbg;

  rom_readback_if bus ();

  rom_readback #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(16)) dut (
    .core_clk   (core_clk),
    .reset      (reset),
    .start      (start),
    .byte_count (byte_count),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .words_sent (words_sent),
    .checksum   (checksum),
    .state_dbg  (state_dbg)
  );

  always #5 core_clk = ~core_clk;

  // Synchronous ROM: data valid the cycle after mem_en.
  logic [31:0] rom [16];
  always @(posedge core_clk) begin
    if (bus.mem_en) bus.mem_dout <= rom[bus.mem_addr[5:2]];
  end

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic gap();
    start = 1'b0;
    bus.fifo_full = 1'b0;
    tick();
    tick();
  endtask

  task automatic chk_reset_vals();
    chk("rst_mem_en", bus.mem_en, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_fifo_din", bus.fifo_din, 32'd0);
    chk("rst_fifo_wr", bus.fifo_wr, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_words_sent", words_sent, 32'd0);
    chk("rst_checksum", checksum, 32'd0);
  endtask

  // Cycle c=1 is the cycle right after the edge that accepts start.
  task automatic run_rb(input logic [31:0] bc, input int full_pct,
                        input int stall_from, input int stall_len, input int toggle_at);
    longint n;
    int c, issue_cyc, next_push, done_cyc, wr_k;
    logic [31:0] sum;
    logic exp_wr;
    n = (longint'(bc) + 3) / 4;
    if (n > 16) n = 16;
    exp_q.delete();
    for (int i = 0; i < int'(n); i++) exp_q.push_back(rom[i]);
    sum = 32'd0;
    wr_k = 0;
    if (n > 0) begin
      issue_cyc = 1; next_push = 3; done_cyc = -1;
    end else begin
      issue_cyc = -1; next_push = -1; done_cyc = 2;
    end
    byte_count = bc;
    start = 1'b1;
    for (c = 1; c <= 400; c++) begin
      @(posedge core_clk);
      #1;
      if (c == toggle_at) start = 1'b0;
      if (c == toggle_at + 1) start = 1'b1;
      bus.fifo_full = ((c >= stall_from) && (c < stall_from + stall_len)) ||
                      ($urandom_range(99) < full_pct);
      #1;
      chk("words_sent_run", words_sent, 32'(wr_k));
      chk("checksum_run", checksum, sum);
      chk("mem_en", bus.mem_en, 32'(c == issue_cyc));
      if (c == issue_cyc) begin
        chk("mem_addr", bus.mem_addr, 32'(wr_k) << 2);
        last_addr = bus.mem_addr;
      end
      exp_wr = 1'b0;
      if (c == next_push) begin
        chk("fifo_din", bus.fifo_din, exp_q[0]);
        if (!bus.fifo_full) begin
          exp_wr = 1'b1;
          sum = sum + exp_q.pop_front();
          wr_k++;
          if (wr_k == int'(n)) begin
            done_cyc = c + 2; next_push = -1;
          end else begin
            issue_cyc = c + 1; next_push = c + 3;
          end
        end else begin
          next_push = c + 1;
        end
      end
      chk("fifo_wr", bus.fifo_wr, 32'(exp_wr));
      chk("busy", busy, 32'((c >= 1) && (done_cyc < 0 || c < done_cyc)));
      chk("done", done, 32'((done_cyc > 0) && (c >= done_cyc)));
      if (done_cyc > 0 && c == done_cyc) break;
    end
    chk("run_end_cycle", 32'(c), 32'(done_cyc));
    chk("words_sent_final", words_sent, n[31:0]);
    chk("checksum_final", checksum, sum);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    bus.fifo_full = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    byte_count = 32'd0;
    bus.fifo_full = 1'b0;
    last_addr = 32'd0;
    for (int i = 0; i < 16; i++) rom[i] = 32'hA000_0000 + 32'(i);
    repeat (3) tick();
    chk_reset_vals();
    reset = 1'b0;
    tick();

    // Basic 16-byte image, then start held high must not restart.
    run_rb(32'd16, 0, 0, 0, -1);
    chk("t1_checksum", checksum, 32'h8000_0006);
    chk("t1_last_addr", last_addr, 32'h0000_000C);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("held_start_busy", busy, 32'd0);
      chk("held_start_mem_en", bus.mem_en, 32'd0);
      chk("held_start_done", done, 32'd1);
    end
    gap();

    run_rb(32'd5, 0, 0, 0, -1);
    chk("bc5_last_addr", last_addr, 32'h0000_0004);
    gap();
    run_rb(32'd0, 0, 0, 0, -1);
    gap();

    // Ten-cycle stall on the second PUSH (cycle 6).
    run_rb(32'd16, 0, 6, 10, -1);
    chk("stall_checksum", checksum, 32'h8000_0006);
    gap();

    // Start toggled while busy is ignored.
    run_rb(32'd16, 0, 0, 0, 5);
    gap();

    // Reset during WAIT of word 3 of 8 (issue at cycle 7, wait at cycle 8).
    byte_count = 32'd32;
    start = 1'b1;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    chk_reset_vals();
    reset = 1'b0;
    gap();
    run_rb(32'd32, 0, 0, 0, -1);
    gap();

    // Clamp to MAX_WORDS.
    run_rb(32'hFFFF_FFFF, 0, 0, 0, -1);
    chk("clamp_words", words_sent, 32'd16);
    chk("clamp_last_addr", last_addr, 32'h0000_003C);
    gap();

    // Random images, sizes and back-pressure.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 16; i++) rom[i] = $urandom();
      run_rb((k == 7) ? $urandom() : 32'($urandom_range(0, 80)),
             int'($urandom_range(0, 50)), 0, 0, -1);
      gap();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_readback.md
# rom_readback

Reads back the program memory after host programming so the host can verify the image. Once enabled, it reads a host-specified number of bytes from the ROM's port A, one 32-bit word at a time, and pushes each word into a write-side FIFO that feeds a host pipe-out. It is the read counterpart of the programming loader (pipe-in FIFO → ROM writes). It runs in the core clock domain while the core is held in program reset, and it owns the ROM port during readback.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word read; bits [1:0] must be 0.
- MAX_WORDS, 16384, upper bound on words per readback (ROM depth).

Ports:
- core_clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high; all state cleared on the next core_clk edge.
- start  in  1  level request (host wire-in bit); a rising edge starts a readback.
- byte_count  in  32  number of bytes to read back; sampled on the accepted start edge.
- mem_en  out  1  ROM port enable.
- mem_addr  out  32  ROM byte address (word aligned; ROM uses [31:2]).
- mem_dout  in  32  ROM read data, valid one cycle after mem_en.
- fifo_din  out  32  word to the pipe-out FIFO.
- fifo_wr  out  1  FIFO write strobe.
- fifo_full  in  1  FIFO full flag; no write while high.
- busy  out  1  readback in progress.
- done  out  1  sticky completion flag.
- words_sent  out  32  words written to the FIFO in the current/last readback.
- checksum  out  32  sum mod 2^32 of the words written in the current/last readback.

## Operation
- Reset values: mem_en=0, mem_addr=BASE_ADDR, fifo_din=0, fifo_wr=0, busy=0, done=0, words_sent=0, checksum=0, state=IDLE, start_q=0.
- start_q is start registered on core_clk. An edge is accepted when start=1, start_q=0, and state=IDLE. Edges seen in any other state are ignored.
- Word count: total = (byte_count + 3) >> 2, computed in 33 bits, then clamped to MAX_WORDS. A partial last word is read whole.
- On an accepted start:
  - latch total;
  - index=0;
  - clear done, words_sent and checksum;
  - busy=1.
  - If total=0, the block goes directly to DONE.
- States:
  - IDLE: wait for an accepted start.
  - ISSUE:
    - mem_en=1, mem_addr = BASE_ADDR + (index << 2), 32-bit wraparound;
    - → WAIT.
  - WAIT:
    - mem_en=0; capture mem_dout into the hold register (drives fifo_din);
    - → PUSH.
  - PUSH:
    - fifo_wr = ~fifo_full (combinational).
    - When the write happens:
      - words_sent+1, checksum += fifo_din, index+1;
      - if index+1 == total → DONE, else → ISSUE.
    - While fifo_full=1: stay in PUSH; fifo_din and mem_addr hold; no ROM access.
  - DONE (1 cycle): busy=0, done=1 → IDLE.
- done stays high until the next accepted start or reset.
- Reset mid-operation: the block aborts immediately and reverts to reset values. Words already written stay in the FIFO; FIFO reset is the host's responsibility.

## Timing
- Start detected at edge t. ISSUE occupies cycle t+1 (mem_en high), WAIT t+2, PUSH t+3. fifo_wr is high in t+3 if not full.
- Steady state: one word every 3 cycles, plus one extra cycle for each cycle fifo_full is high during PUSH.
- busy rises at t+1 and falls the edge after the last write. done rises on that same edge.
- total=0: busy is high for one cycle (DONE), then done=1. No mem_en, no fifo_wr.
- fifo_wr is never asserted while fifo_full=1. mem_en is never asserted outside ISSUE.
- If fifo_full rises in the same cycle as PUSH entry, there is no write that cycle.

## Test plan
- BASE_ADDR=0, ROM[i]=32'hA000_0000+i, byte_count=16, pulse start → FIFO receives A0000000..A0000003 in order; addresses 0,4,8,C; words_sent=4; checksum=32'h8000_0006; done=1.
- byte_count=5 → exactly 2 words (addr 0,4); byte_count=0 → done=1 two cycles after the start edge, with zero fifo_wr and zero mem_en.
- Force fifo_full high for 10 cycles at the second PUSH → no write and no mem_en during the stall; fifo_din stable; the second word is written on the first cycle full drops; final data is unchanged.
- Reset asserted during WAIT of word 3 of 8 → the next cycle shows all outputs at reset values; a new start then reads from index 0.
- Toggle start low→high while busy → ignored, count unchanged. Hold start high after DONE → no restart until start goes low then high again.
- byte_count=32'hFFFF_FFFF with MAX_WORDS=16 → exactly 16 words; the last address is BASE_ADDR+0x3C.
